// File: rtl/byte_pair_packer.sv
`default_nettype none
// ============================================================================
// Module      : byte_pair_packer
// Description : Packs an 8-bit byte stream into 16-bit words carried on a
//               valid/ready stream. A packet whose final byte arrives as the
//               first byte of a pair is padded with PAD in the empty lane.
//               A DEPTH-word circular FIFO sits between the packer and the
//               output so producer and consumer back-pressure are decoupled.
// Parameters  : SWAP  - 1: first byte in out_data[15:8]; 0: in out_data[7:0]
//               DEPTH - output FIFO depth in words (power of two, >= 2)
//               PAD   - filler byte for the empty lane of a padded word
// Ports       : CLK        in   clock, all state changes on rising edge
//               RESET      in   synchronous active-high reset
//               in_data    in   [7:0] input byte
//               in_valid   in   in_data/in_last valid
//               in_last    in   byte is the final byte of a packet
//               in_ready   out  byte accepted when in_valid && in_ready
//               out_data   out  [15:0] packed word at FIFO head
//               out_valid  out  FIFO non-empty
//               out_last   out  word holds the final byte of a packet
//               out_pad    out  word holds one real byte plus PAD
//               out_ready  in   word consumed when out_valid && out_ready
// Revision    : 1.0 - initial release
// ============================================================================
module byte_pair_packer #(
  parameter bit         SWAP  = 1'b1,
  parameter int         DEPTH = 2,
  parameter logic [7:0] PAD   = 8'h00
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  output logic        out_last,
  output logic        out_pad,
  input  logic        out_ready
);

  localparam int              c_AW      = $clog2(DEPTH);
  localparam int              c_EW      = 18;  // {data[15:0], last, pad}
  localparam logic [c_AW:0]   c_FULL    = (c_AW + 1)'(DEPTH);
  localparam logic [c_AW:0]   c_CNT_ONE = (c_AW + 1)'(1);
  localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_held;
  logic [c_EW-1:0]   r_mem [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_AW:0]     r_count;

  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_load;
  logic [15:0]       w_word;
  logic              w_word_last;
  logic              w_word_pad;

  // Ready depends on registered occupancy only. Blocking every byte when
  // full (even one that would only be held) keeps in_ready free of any
  // path from in_last or out_ready.
  assign in_ready  = (r_count != c_FULL);
  assign out_valid = (r_count != '0);
  assign w_accept  = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // The head entry drives the outputs directly, so they stay stable for as
  // long as the head is not popped.
  assign out_data  = r_mem[r_rd_ptr][17:2];
  assign out_last  = r_mem[r_rd_ptr][1];
  assign out_pad   = r_mem[r_rd_ptr][0];

  // --------------------------------------------------------------------------
  // Packer FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_load      = 1'b0;
    w_word      = '0;
    w_word_last = 1'b0;
    w_word_pad  = 1'b0;
    if (w_accept) begin
      case (r_state)
        ST_EMPTY: begin
          if (in_last) begin
            // Single-byte tail: emit immediately with PAD in the other lane.
            w_push      = 1'b1;
            w_word      = SWAP ? {in_data, PAD} : {PAD, in_data};
            w_word_last = 1'b1;
            w_word_pad  = 1'b1;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = ST_HALF;
          end
        end
        ST_HALF: begin
          w_push      = 1'b1;
          w_word      = SWAP ? {r_held, in_data} : {in_data, r_held};
          w_word_last = in_last;
          w_state_nxt = ST_EMPTY;
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_held <= '0;
    end else if (w_load) begin
      r_held <= in_data;
    end
  end

  // --------------------------------------------------------------------------
  // Output FIFO (pointers wrap naturally since DEPTH is a power of two)
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {w_word, w_word_last, w_word_pad};
        r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_byte_pair_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_byte_pair_packer
// Description : Testbench for byte_pair_packer. Two instances share one
//               stimulus: instance A (SWAP=1, PAD=8'h00) and instance B
//               (SWAP=0, PAD=8'hA5). A packet-level reference model turns
//               accepted bytes into expected words kept in per-instance
//               queues that mirror the expected output FIFO contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_pair_packer;

  localparam int         c_DEPTH = 2;
  localparam logic [7:0] c_PAD_A = 8'h00;
  localparam logic [7:0] c_PAD_B = 8'hA5;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_a, out_valid_a, out_last_a, out_pad_a;
  logic [15:0] out_data_a;
  logic        in_ready_b, out_valid_b, out_last_b, out_pad_b;
  logic [15:0] out_data_b;

  always #5 CLK = ~CLK;

  byte_pair_packer #(.SWAP(1'b1), .DEPTH(c_DEPTH), .PAD(c_PAD_A)) u_dut_a (
    .CLK(CLK), .RESET(RESET),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_last(out_last_a),
    .out_pad(out_pad_a), .out_ready(out_ready)
  );

  byte_pair_packer #(.SWAP(1'b0), .DEPTH(c_DEPTH), .PAD(c_PAD_B)) u_dut_b (
    .CLK(CLK), .RESET(RESET),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_last(out_last_b),
    .out_pad(out_pad_b), .out_ready(out_ready)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: bytes of the current pair still waiting for a
  // partner, and expected outputs {data, last, pad} per instance.
  logic [7:0]  pend[$];
  logic [17:0] qa[$];
  logic [17:0] qb[$];
  bit          last_acc;
  int          accepted;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Packet rule: a word is formed from two bytes, or from a lone final byte
  // plus PAD in the lane the second byte would have used.
  task automatic model_byte(input logic [7:0] d, input logic l);
    logic [7:0] first, second_a, second_b;
    bit         padded;
    if (pend.size() == 0 && !l) begin
      pend.push_back(d);
    end else begin
      padded   = (pend.size() == 0);
      first    = padded ? d : pend[0];
      second_a = padded ? c_PAD_A : d;
      second_b = padded ? c_PAD_B : d;
      qa.push_back({first, second_a, 1'b1 & l, padded});
      qb.push_back({second_b, first, 1'b1 & l, padded});
      pend.delete();
    end
  endtask

  task automatic check_outputs();
    chk("a.in_ready",  {15'd0, in_ready_a},  {15'd0, qa.size() < c_DEPTH});
    chk("a.out_valid", {15'd0, out_valid_a}, {15'd0, qa.size() != 0});
    if (qa.size() != 0) begin
      chk("a.out_data", out_data_a, qa[0][17:2]);
      chk("a.out_last", {15'd0, out_last_a}, {15'd0, qa[0][1]});
      chk("a.out_pad",  {15'd0, out_pad_a},  {15'd0, qa[0][0]});
    end
    chk("b.in_ready",  {15'd0, in_ready_b},  {15'd0, qb.size() < c_DEPTH});
    chk("b.out_valid", {15'd0, out_valid_b}, {15'd0, qb.size() != 0});
    if (qb.size() != 0) begin
      chk("b.out_data", out_data_b, qb[0][17:2]);
      chk("b.out_last", {15'd0, out_last_b}, {15'd0, qb[0][1]});
      chk("b.out_pad",  {15'd0, out_pad_b},  {15'd0, qb[0][0]});
    end
  endtask

  // One clock: check outputs on the falling edge, drive new inputs, then
  // advance the model at the rising edge. Returns at the rising edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic l,
                       input logic ordy, input logic rst = 1'b0);
    bit acc, pop;
    @(negedge CLK);
    check_outputs();
    RESET     = rst;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = ordy;
    acc = v && !rst && (qa.size() < c_DEPTH);
    pop = ordy && !rst && (qa.size() != 0);
    @(posedge CLK);
    if (rst) begin
      pend.delete();
      qa.delete();
      qb.delete();
    end else begin
      if (pop) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
      if (acc) model_byte(d, l);
    end
    last_acc = acc;
    if (acc) accepted++;
  endtask

  initial begin
    logic [7:0] bytes6 [6];
    logic [7:0] cur_d;
    logic       cur_l;
    int         idx;
    int         cyc;

    // Reset state
    repeat (2) @(posedge CLK);
    #2;
    chk("rst.a.in_ready",  {15'd0, in_ready_a},  16'd1);
    chk("rst.a.out_valid", {15'd0, out_valid_a}, 16'd0);
    chk("rst.a.out_data",  out_data_a,           16'h0000);
    chk("rst.a.out_last",  {15'd0, out_last_a},  16'd0);
    chk("rst.a.out_pad",   {15'd0, out_pad_a},   16'd0);
    chk("rst.b.out_valid", {15'd0, out_valid_b}, 16'd0);
    chk("rst.b.out_data",  out_data_b,           16'h0000);

    // Two-byte packet, both lane orders
    cycle(1'b1, 8'hAB, 1'b0, 1'b1);
    cycle(1'b1, 8'hCD, 1'b1, 1'b1);
    #2;
    chk("t1.a.valid", {15'd0, out_valid_a}, 16'd1);
    chk("t1.a.data",  out_data_a,           16'hABCD);
    chk("t1.a.last",  {15'd0, out_last_a},  16'd1);
    chk("t1.a.pad",   {15'd0, out_pad_a},   16'd0);
    chk("t2.b.data",  out_data_b,           16'hCDAB);

    // Single-byte packet is padded; FSM stays EMPTY so the next pair packs clean
    cycle(1'b1, 8'h5A, 1'b1, 1'b1);
    #2;
    chk("t3.a.data", out_data_a,          16'h5A00);
    chk("t3.a.pad",  {15'd0, out_pad_a},  16'd1);
    chk("t3.b.data", out_data_b,          16'hA55A);
    cycle(1'b1, 8'h01, 1'b0, 1'b1);
    cycle(1'b1, 8'h02, 1'b1, 1'b1);
    #2;
    chk("t3.a.next", out_data_a, 16'h0102);

    // Back-pressure: six bytes with out_ready low, then release
    bytes6 = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    idx = 0;
    for (int t = 0; t < 14; t++) begin
      cycle(idx < 6, (idx < 6) ? bytes6[idx] : 8'h00, idx == 5, t >= 7);
      if (last_acc) idx++;
      if (t == 5) begin
        #2;
        chk("t4.stall_ready", {15'd0, in_ready_a}, 16'd0);
        chk("t4.stall_count", idx[15:0], 16'd4);
      end
    end
    chk("t4.all_bytes", idx[15:0], 16'd6);

    // Reset mid-packet discards the held byte
    cycle(1'b1, 8'h11, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    #2;
    chk("t5.rst.valid", {15'd0, out_valid_a}, 16'd0);
    chk("t5.rst.data",  out_data_a,           16'h0000);
    cycle(1'b1, 8'h22, 1'b0, 1'b1);
    cycle(1'b1, 8'h33, 1'b1, 1'b1);
    #2;
    chk("t5.a.data", out_data_a, 16'h2233);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Random valid/ready toggling over 1000 bytes; a byte is held until taken
    accepted = 0;
    cyc = 0;
    cur_d = 8'($urandom);
    cur_l = ($urandom_range(0, 4) == 0);
    while (accepted < 1000 && cyc < 20000) begin
      if (accepted == 999) cur_l = 1'b1;
      cycle($urandom_range(0, 3) != 0, cur_d, cur_l, $urandom_range(0, 2) != 0);
      if (last_acc) begin
        cur_d = 8'($urandom);
        cur_l = ($urandom_range(0, 4) == 0);
      end
      cyc++;
    end
    chk("t6.budget", accepted[15:0], 16'd1000);
    repeat (6) cycle(1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge CLK);
    check_outputs();
    chk("t6.drained", {15'd0, out_valid_a}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
